// File: rtl/pipe_pkg.sv
// Shared constants and beat layout for the result pipeline skid register.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned RD_W_DEF   = 6;

    typedef struct packed {
        logic                  we;
        logic [RD_W_DEF-1:0]   rd;
        logic [DATA_W_DEF-1:0] data;
    } beat_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for result beats with destination-register forwarding lookup.
// Optional PIPE_TRACE_EN adds trace_result, the data of the most recent output transfer.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_W   = RD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic [RD_W-1:0]   fwd_sel,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`ifdef PIPE_TRACE_EN
    ,
    output logic [DATA_W-1:0] trace_result
`endif
);

    // Same field order as pipe_pkg::beat_t, sized by this instance's parameters.
    typedef struct packed {
        logic              we;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic   main_valid, main_valid_n;
    logic   skid_valid, skid_valid_n;
    entry_t main_q, main_n;
    entry_t skid_q, skid_n;
    entry_t in_beat;
    logic   accept;
    logic   pop;

    assign in_beat = '{we: in_we, rd: in_rd, data: in_data};
    assign accept  = in_valid & ~skid_valid;
    assign pop     = main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            main_q     <= main_n;
            skid_q     <= skid_n;
        end
    end

    // Occupancy update: the head leaves first, then an accepted beat fills the first free slot.
    always_comb begin
        main_valid_n = main_valid;
        skid_valid_n = skid_valid;
        main_n       = main_q;
        skid_n       = skid_q;
        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else begin
            if (pop) begin
                if (skid_valid) begin
                    main_n       = skid_q;
                    skid_valid_n = 1'b0;
                end else begin
                    main_valid_n = 1'b0;
                end
            end
            if (accept) begin
                if (!main_valid_n) begin
                    main_n       = in_beat;
                    main_valid_n = 1'b1;
                end else begin
                    skid_n       = in_beat;
                    skid_valid_n = 1'b1;
                end
            end
        end
    end

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_we    = main_q.we;
    assign out_rd    = main_q.rd;
    assign out_data  = main_q.data;

    // Skid is the younger beat, so it wins when both entries target the same register.
    logic sel_nz, skid_hit, main_hit;

    assign sel_nz   = |fwd_sel;
    assign skid_hit = sel_nz & skid_valid & skid_q.we & (skid_q.rd == fwd_sel);
    assign main_hit = sel_nz & main_valid & main_q.we & (main_q.rd == fwd_sel);
    assign fwd_hit  = skid_hit | main_hit;
    assign fwd_data = skid_hit ? skid_q.data : (main_hit ? main_q.data : '0);

`ifdef PIPE_TRACE_EN
    logic [DATA_W-1:0] trace_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_q <= '0;
        end else if (pop) begin
            trace_q <= main_q.data;
        end
    end

    assign trace_result = trace_q;
`else
    // No trace state in the default build.
`endif

endmodule
